// File: rtl/mandelbrot_pkg.sv
// Shared field layout, defaults and state encoding for the
// Mandelbrot cluster datapath.
package mandelbrot_pkg;

   localparam int VEC_W = 152;
   localparam int PTR_LSB = 120;
   localparam int PTR_W = 32;
   localparam int LC_LSB = 112;
   localparam int LC_W = 8;
   localparam int STEP_LSB = 80;
   localparam int STEP_W = 32;
   localparam int ITER_LSB = 64;
   localparam int ITER_W = 16;
   localparam int CR_LSB = 32;
   localparam int CR_W = 32;
   localparam int CI_LSB = 0;
   localparam int CI_W = 32;

   localparam int CMD_W = 64;
   localparam int CMD_LEN_LSB = 32;
   localparam int CMD_ADDR_LSB = 0;

   localparam int CRD_W = 80;
   localparam int CRD_ITER_LSB = 64;
   localparam int CRD_CR_LSB = 32;
   localparam int CRD_CI_LSB = 0;

   localparam int CNT_W = 11;
   localparam int PPL_DEFAULT = 8;
   localparam int BPP_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      SEND_CMD = 2'b01,
      FEED     = 2'b10
   } state_t;

   typedef struct packed {
      logic [PTR_W-1:0]  pix_buf_ptr;
      logic [LC_W-1:0]   line_count;
      logic [STEP_W-1:0] step_dim;
      logic [ITER_W-1:0] max_iters;
      logic [CR_W-1:0]   cr;
      logic [CI_W-1:0]   ci;
   } work_vec_t;

   typedef struct packed {
      logic [31:0] length;
      logic [31:0] address;
   } dma_cmd_t;

   typedef struct packed {
      logic [ITER_W-1:0] max_iters;
      logic [CR_W-1:0]   cr;
      logic [CI_W-1:0]   ci;
   } coord_t;

endpackage

// File: rtl/mandelbrot_coord_stepper.sv
// Real-axis accumulator and pixel counter for one cluster;
// last is registered so it is ready alongside the coordinate.
module mandelbrot_coord_stepper
   import mandelbrot_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic [CR_W-1:0]  cr_init,
   input  logic [STEP_W-1:0] step_dim,
   input  logic [CNT_W-1:0] total,
   output logic [CR_W-1:0]  cr_cur,
   output logic             last
);

   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  total_q;
   logic [STEP_W-1:0] step_q;
   logic [CNT_W:0]    count_p2;

   assign count_p2 = {1'b0, count} + (CNT_W+1)'(2);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cr_cur  <= '0;
         count   <= '0;
         total_q <= '0;
         step_q  <= '0;
         last    <= 1'b0;
      end else if (load) begin
         cr_cur  <= cr_init;
         count   <= '0;
         total_q <= total;
         step_q  <= step_dim;
         last    <= (total == CNT_W'(1));
      end else if (step) begin
         cr_cur <= cr_cur + step_q;
         count  <= count + CNT_W'(1);
         // pixel after this one is the final one
         last   <= (count_p2 == {1'b0, total_q});
      end
   end

endmodule

// File: rtl/mandelbrot_cluster_unpacker.sv
// Turns one cluster work vector into a DMA write command followed
// by a stream of per-pixel coordinates for the iteration engines.
module mandelbrot_cluster_unpacker
   import mandelbrot_pkg::*;
#(
   parameter int PIXELS_PER_LINE = PPL_DEFAULT,
   parameter int BYTES_PER_PIXEL = BPP_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [VEC_W-1:0] in_vector_snk_data,
   input  logic             in_vector_snk_valid,
   output logic             in_vector_snk_ready,
   output logic [CMD_W-1:0] dma_cmd_src_data,
   output logic             dma_cmd_src_valid,
   input  logic             dma_cmd_src_ready,
   output logic [CRD_W-1:0] coord_src_data,
   output logic             coord_src_valid,
   input  logic             coord_src_ready,
   output logic             coord_src_last,
   output logic             err_zero_count
);

   work_vec_t         vec;
   state_t            state, state_nxt;
   logic              accept;
   logic              zero_lc;
   logic              step;
   logic              last_q;
   logic [CNT_W-1:0]  total_new;
   logic [31:0]       len_new;
   dma_cmd_t          cmd_q;
   logic [ITER_W-1:0] iters_q;
   logic [CI_W-1:0]   ci_q;
   logic [CR_W-1:0]   cr_cur;

   assign vec = work_vec_t'(in_vector_snk_data);
   assign accept = in_vector_snk_valid && in_vector_snk_ready;
   assign zero_lc = (vec.line_count == '0);

   assign total_new = CNT_W'({3'b000, vec.line_count}
                      * CNT_W'(PIXELS_PER_LINE));
   assign len_new = 32'(total_new) * 32'(BYTES_PER_PIXEL);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         cmd_q          <= '0;
         iters_q        <= '0;
         ci_q           <= '0;
         err_zero_count <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            cmd_q   <= '{length: len_new, address: vec.pix_buf_ptr};
            iters_q <= vec.max_iters;
            ci_q    <= vec.ci;
            if (zero_lc)
               err_zero_count <= 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:
            if (accept && !zero_lc)
               state_nxt = SEND_CMD;
         SEND_CMD:
            if (dma_cmd_src_ready)
               state_nxt = FEED;
         FEED:
            if (coord_src_ready && last_q)
               state_nxt = IDLE;
         default:
            state_nxt = IDLE;
      endcase
   end

   assign in_vector_snk_ready = (state == IDLE);
   assign dma_cmd_src_valid = (state == SEND_CMD);
   assign coord_src_valid = (state == FEED);
   assign step = coord_src_valid && coord_src_ready;

   mandelbrot_coord_stepper u_stepper (
      .clk      (clk),
      .reset    (reset),
      .load     (accept),
      .step     (step),
      .cr_init  (vec.cr),
      .step_dim (vec.step_dim),
      .total    (total_new),
      .cr_cur   (cr_cur),
      .last     (last_q)
   );

   assign dma_cmd_src_data = cmd_q;
   assign coord_src_data = {iters_q, cr_cur, ci_q};
   assign coord_src_last = coord_src_valid && last_q;

endmodule

// File: tb/tb_mandelbrot_cluster_unpacker.sv
// Randomized bench for the cluster unpacker against a
// queue-based reference of expected commands and coordinates.
module tb_mandelbrot_cluster_unpacker;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [151:0] in_data = '0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [63:0]  dma_data;
   logic         dma_valid;
   logic         dma_ready = 1'b0;
   logic [79:0]  crd_data;
   logic         crd_valid;
   logic         crd_ready = 1'b0;
   logic         crd_last;
   logic         err;

   mandelbrot_cluster_unpacker dut (
      .clk                 (clk),
      .reset               (reset),
      .in_vector_snk_data  (in_data),
      .in_vector_snk_valid (in_valid),
      .in_vector_snk_ready (in_ready),
      .dma_cmd_src_data    (dma_data),
      .dma_cmd_src_valid   (dma_valid),
      .dma_cmd_src_ready   (dma_ready),
      .coord_src_data      (crd_data),
      .coord_src_valid     (crd_valid),
      .coord_src_ready     (crd_ready),
      .coord_src_last      (crd_last),
      .err_zero_count      (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [79:0] d;
      bit          last;
      int          due;
   } exp_t;

   exp_t  cmdq[$];
   exp_t  crdq[$];
   int    n_tests = 0;
   int    n_fail = 0;
   int    cyc = 0;
   bit    bp = 0;
   bit    nobp = 0;
   bit    junk = 0;
   bit    vec_pend = 0;
   bit    acc_seen = 0;
   bit    err_exp = 0;
   int    dma_hold = 0;
   bit    pd_stall = 0;
   bit    pc_stall = 0;
   logic [63:0] pd_data;
   logic [79:0] pc_data;
   bit          pc_last;

   task automatic check(input string tag, input logic [79:0] got,
                        input logic [79:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected traffic is derived directly from the vector fields.
   task automatic model_accept(input logic [151:0] v);
      logic [31:0] ptr, step, cr, ci, c;
      logic [15:0] it;
      int lc, total;
      exp_t e;
      ptr = v[151:120];
      lc = int'(v[119:112]);
      step = v[111:80];
      it = v[79:64];
      cr = v[63:32];
      ci = v[31:0];
      if (lc == 0) begin
         err_exp = 1;
         return;
      end
      total = lc * 8;
      e.d = {16'h0, 32'(total * 4), ptr};
      e.last = 0;
      e.due = cyc + 1;
      cmdq.push_back(e);
      for (int k = 0; k < total; k++) begin
         c = cr + 32'(k) * step;
         e.d = {it, c, ci};
         e.last = (k == total - 1);
         e.due = cyc + 2 + k;
         crdq.push_back(e);
      end
   endtask

   task automatic observe();
      exp_t e;
      check("in_rdy", in_ready, (cmdq.size() == 0 && crdq.size() == 0));
      check("err", err, err_exp);
      if (pd_stall) begin
         check("cmd_hold_v", dma_valid, 1);
         check("cmd_hold_d", dma_data, pd_data);
      end
      if (pc_stall) begin
         check("crd_hold_v", crd_valid, 1);
         check("crd_hold_d", crd_data, pc_data);
         check("crd_hold_l", crd_last, pc_last);
      end
      if (dma_valid && dma_hold > 0)
         dma_hold--;
      if (dma_valid && dma_ready) begin
         if (cmdq.size() == 0)
            check("cmd_unexp", dma_valid, 0);
         else begin
            e = cmdq.pop_front();
            check("cmd", dma_data, e.d);
            if (nobp) check("cmd_lat", cyc, e.due);
         end
      end
      if (crd_valid && crd_ready) begin
         if (cmdq.size() != 0)
            check("crd_order", cmdq.size(), 0);
         if (crd_valid && crd_ready && crdq.size() == 0)
            check("crd_unexp", crd_valid, 0);
         else begin
            e = crdq.pop_front();
            check("crd", crd_data, e.d);
            check("last", crd_last, e.last);
            if (nobp) check("crd_lat", cyc, e.due);
         end
      end
      pd_stall = dma_valid && !dma_ready;
      pd_data = dma_data;
      pc_stall = crd_valid && !crd_ready;
      pc_data = crd_data;
      pc_last = crd_last;
      if (in_valid && in_ready) begin
         model_accept(in_data);
         acc_seen = 1;
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      observe();
      @(posedge clk);
      cyc++;
      #1;
      crd_ready = bp ? 1'($urandom % 2) : 1'b1;
      dma_ready = (dma_hold > 0) ? 1'b0 :
                  (bp ? 1'($urandom % 2) : 1'b1);
      if (acc_seen && vec_pend)
         in_valid = 1'b0;
      else if (vec_pend)
         in_valid = bp ? 1'($urandom % 2) : 1'b1;
      else if (junk && (cmdq.size() + crdq.size()) > 0) begin
         in_valid = 1'($urandom % 2);
         in_data = {$urandom, $urandom, $urandom, $urandom, $urandom};
      end else
         in_valid = 1'b0;
   endtask

   task automatic run_vec(input logic [7:0] lc, input logic [31:0] ptr,
                          input logic [31:0] cr, input logic [31:0] step,
                          input logic [31:0] ci, input logic [15:0] it,
                          input bit drain);
      int n;
      in_data = {ptr, lc, step, it, cr, ci};
      in_valid = 1'b1;
      acc_seen = 0;
      vec_pend = 1;
      n = 0;
      while (!acc_seen && n < 100) begin
         cycle();
         n++;
      end
      vec_pend = 0;
      check("acc_timeout", acc_seen, 1);
      if (!drain) return;
      junk = 1;
      n = 0;
      while ((cmdq.size() + crdq.size()) > 0 && n < 20000) begin
         cycle();
         n++;
      end
      junk = 0;
      check("drain_timeout", cmdq.size() + crdq.size(), 0);
      cycle();
   endtask

   initial begin
      #3;
      check("rst_in_rdy", in_ready, 1);
      check("rst_dma_v", dma_valid, 0);
      check("rst_crd_v", crd_valid, 0);
      check("rst_last", crd_last, 0);
      check("rst_err", err, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      dma_ready = 1'b1;
      crd_ready = 1'b1;

      nobp = 1;
      run_vec(8'd1, 32'h2000_0000, 32'h1000_0000, 32'h0010_0000,
              32'h0200_0000, 16'd256, 1);
      run_vec(8'd1, 32'h3000_0000, 32'hFFF0_0000, 32'h0008_0000,
              32'h0000_1234, 16'd100, 1);
      nobp = 0;

      bp = 1;
      for (int i = 0; i < 3; i++)
         run_vec(8'd4, $urandom, $urandom, $urandom, $urandom,
                 16'($urandom), 1);
      run_vec(8'd0, $urandom, $urandom, $urandom, $urandom, 16'd7, 1);
      run_vec(8'd2, 32'h4000_0000, $urandom, $urandom, $urandom,
              16'd9, 1);

      run_vec(8'd8, 32'h5000_0000, $urandom, $urandom, $urandom,
              16'd50, 0);
      repeat (12) cycle();
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_dma_v", dma_valid, 0);
      check("mid_rst_crd_v", crd_valid, 0);
      check("mid_rst_rdy", in_ready, 1);
      check("mid_rst_err", err, 0);
      cmdq.delete();
      crdq.delete();
      pd_stall = 0;
      pc_stall = 0;
      err_exp = 0;
      @(posedge clk);
      #1 reset = 1'b0;
      run_vec(8'd3, 32'h6000_0000, $urandom, $urandom, $urandom,
              16'd77, 1);

      bp = 0;
      dma_hold = 10;
      dma_ready = 1'b0;
      run_vec(8'd255, 32'h7000_0000, $urandom, $urandom, $urandom,
              16'd1000, 1);

      bp = 1;
      for (int i = 0; i < 6; i++)
         run_vec(8'($urandom_range(0, 16)), $urandom, $urandom,
                 $urandom, $urandom, 16'($urandom), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
